mac_dot_controller: RTL and testbench
=====================================

MAC_DOT_CONTROLLER -- requirements
Module: mac_dot_controller

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter EXP_WIDTH, default 8, exponent width passed to the MAC datapath.
REQ-003 SHALL have parameter MANT_WIDTH, default 7, mantissa width passed to the MAC datapath.
REQ-004 SHALL have parameter TRUNC_MANTISSA_MBM_BITS, default 6, passed unchanged to the multiplier inside mac_unit.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, width of the vector-length field.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port start  input  1  request a new dot product; sampled only in IDLE.
REQ-009 SHALL have port vec_len  input  LEN_WIDTH  number of element pairs N, captured with start.
REQ-010 SHALL have port acc_init  input  BIT_WIDTH  initial accumulator value (bias), captured with start.
REQ-011 SHALL have port op_valid  input  1  in_a/in_b pair valid.
REQ-012 SHALL have port op_ready  output  1  controller accepts a pair this cycle.
REQ-013 SHALL have port in_a, in_b  input  BIT_WIDTH each  element pair.
REQ-014 SHALL have port abort  input  1  synchronous cancel of the current job.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  consumer takes result.
REQ-017 SHALL have port result  output  BIT_WIDTH  final accumulator value.
REQ-018 SHALL have port exception, overflow, underflow  output  1 each  sticky job flags.
REQ-019 SHALL have port busy  output  1  high when not IDLE.

Function
REQ-020 SHALL instantiate one mac_unit with in_a/in_b from the ports, in_c from the accumulator register acc, same parameter values.
REQ-021 SHALL implement FSM IDLE, RUN, DONE.
REQ-022 IDLE: start=1 and vec_len!=0 -> RUN; acc<=acc_init, cnt<=vec_len, flags cleared.
REQ-023 IDLE: start=1 and vec_len==0 -> DONE directly; acc<=acc_init, flags cleared.
REQ-024 start SHALL be ignored in RUN and DONE.
REQ-025 op_ready SHALL be 1 exactly in RUN; a pair is accepted on a cycle with op_valid&op_ready.
REQ-026 On accept: acc<=mac_out, cnt<=cnt-1, exception/overflow/underflow |= corresponding mac_unit outputs.
REQ-027 On accept with cnt==1: -> DONE in the same edge; no further pairs accepted.
REQ-028 op_valid=0 in RUN SHALL stall with acc, cnt, flags unchanged.
REQ-029 DONE: res_valid=1, result=acc; held stable until res_valid&res_ready, then -> IDLE.
REQ-030 result SHALL equal acc in all states; res_valid=0 outside DONE.
REQ-031 Latency: result valid the cycle after the Nth accepted pair (1 cycle per element, no bubbles when op_valid held high).
REQ-032 abort=1 in RUN or DONE SHALL force IDLE next edge; acc, flags retain value; no res_valid pulse; abort has priority over accept/handshake; ignored in IDLE.
REQ-033 Flags SHALL remain stable from DONE until the next accepted start.
REQ-034 cnt SHALL be LEN_WIDTH bits; vec_len = 2^LEN_WIDTH-1 supported without wrap.

Reset
REQ-035 rst=1 SHALL asynchronously force IDLE, acc=0, cnt=0, res_valid=0, op_ready=0, busy=0, all flags=0, result=0.
REQ-036 Reset asserted mid-RUN or mid-DONE SHALL discard the job; after release, start is required before any accept.

Verification
REQ-037 bf16: start, vec_len=2, acc_init=0x0000; pairs (0x3F80,0x4000),(0x4000,0x4040) back-to-back -> res_valid on cycle 3 after start, result=0x4100 (8.0), flags 0.
REQ-038 vec_len=0, acc_init=0x3F00 -> DONE next cycle, result=0x3F00, op_ready never high.
REQ-039 vec_len=3 with op_valid gaps of 2 cycles between pairs (1.0*1.0 each) -> result=0x4040, acc unchanged during gaps, res_valid held while res_ready=0 for 4 cycles.
REQ-040 Pair 0x7F00*0x7F00 (overflow) in a 2-element job -> overflow=1 sticky through DONE, cleared on next start.
REQ-041 abort in RUN after 1 of 4 pairs -> IDLE next cycle, busy=0, no res_valid; start during RUN/DONE ignored.
REQ-042 rst asserted asynchronously mid-RUN (between edges) -> all outputs at reset values immediately; new job after release gives correct result.

Source files
------------

// File: rtl/mac_dot_controller.sv
// Dot-product sequencer around a truncating bf16-style fused multiply-add.
// mac_mult/mac_add flush subnormals to zero and round toward zero.
module mac_mult #(
  parameter int BIT_WIDTH               = 16,
  parameter int EXP_WIDTH               = 8,
  parameter int MANT_WIDTH              = 7,
  parameter int TRUNC_MANTISSA_MBM_BITS = 6
) (
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  output logic [BIT_WIDTH-1:0] prod,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int PW = 2 * MANT_WIDTH + 2;
  localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
  localparam logic [PW-1:0] TRUNC_MASK = {PW{1'b1}} << TRUNC_MANTISSA_MBM_BITS;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

  logic                  w_sign;
  logic [EXP_WIDTH-1:0]  w_ea, w_eb;
  logic [MANT_WIDTH-1:0] w_ma, w_mb, w_mant;
  logic [PW-1:0]         w_prod;
  logic                  w_norm;
  logic [MANT_WIDTH-1:0] w_unused_lsbs;
  int                    v_exp;

  assign w_sign = in_a[BIT_WIDTH-1] ^ in_b[BIT_WIDTH-1];
  assign w_ea   = in_a[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_eb   = in_b[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_ma   = in_a[MANT_WIDTH-1:0];
  assign w_mb   = in_b[MANT_WIDTH-1:0];
  // Low product bits are dropped before normalisation to shorten the multiplier.
  assign w_prod = ({{(MANT_WIDTH+1){1'b0}}, 1'b1, w_ma} * {{(MANT_WIDTH+1){1'b0}}, 1'b1, w_mb}) & TRUNC_MASK;
  assign w_norm = w_prod[PW-1];
  assign w_mant = w_norm ? w_prod[PW-2 -: MANT_WIDTH] : w_prod[PW-3 -: MANT_WIDTH];
  assign w_unused_lsbs = w_prod[MANT_WIDTH-1:0];

  always_comb begin
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    prod      = {w_sign, {(BIT_WIDTH-1){1'b0}}};
    v_exp     = int'(w_ea) + int'(w_eb) - BIAS + int'(w_norm);
    if (w_ea == EXP_MAX || w_eb == EXP_MAX) begin
      exception = 1'b1;
      prod      = {w_sign, EXP_MAX, {MANT_WIDTH{1'b0}}};
    end else if (w_ea == '0 || w_eb == '0) begin
      prod = {w_sign, {(BIT_WIDTH-1){1'b0}}};
    end else if (v_exp >= int'(EXP_MAX)) begin
      overflow = 1'b1;
      prod     = {w_sign, EXP_MAX, {MANT_WIDTH{1'b0}}};
    end else if (v_exp <= 0) begin
      underflow = 1'b1;
    end else begin
      prod = {w_sign, v_exp[EXP_WIDTH-1:0], w_mant};
    end
  end
endmodule

module mac_add #(
  parameter int BIT_WIDTH  = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7
) (
  input  logic [BIT_WIDTH-1:0] in_x,
  input  logic [BIT_WIDTH-1:0] in_c,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int AW = MANT_WIDTH + 5;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

  logic                  w_sx, w_sc;
  logic [EXP_WIDTH-1:0]  w_ex, w_ec;
  logic [MANT_WIDTH-1:0] w_mx, w_mc;
  logic                  v_bs;
  logic [EXP_WIDTH-1:0]  v_be, v_se;
  logic [MANT_WIDTH-1:0] v_bm, v_smm;
  logic [AW-1:0]         v_big, v_sml, v_sum;
  int                    v_e;

  assign {w_sx, w_ex, w_mx} = in_x;
  assign {w_sc, w_ec, w_mc} = in_c;

  always_comb begin
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    sum       = in_c;
    v_bs      = w_sx;
    {v_be, v_bm}  = {w_ex, w_mx};
    {v_se, v_smm} = {w_ec, w_mc};
    if ({w_ec, w_mc} > {w_ex, w_mx}) begin
      v_bs          = w_sc;
      {v_be, v_bm}  = {w_ec, w_mc};
      {v_se, v_smm} = {w_ex, w_mx};
    end
    v_big = {2'b01, v_bm, 3'b000};
    v_sml = {2'b01, v_smm, 3'b000} >> (int'(v_be) - int'(v_se));
    v_e   = int'(v_be);
    v_sum = '0;
    if (w_ex == EXP_MAX) begin
      sum = in_x;
    end else if (w_ec == EXP_MAX) begin
      exception = 1'b1;
      sum       = in_c;
    end else if (w_ex == '0 && w_ec == '0) begin
      sum = {w_sx & w_sc, {(BIT_WIDTH-1){1'b0}}};
    end else if (w_ex == '0) begin
      sum = in_c;
    end else if (w_ec == '0) begin
      sum = in_x;
    end else begin
      if (w_sx == w_sc) begin
        v_sum = v_big + v_sml;
        if (v_sum[AW-1]) begin
          v_sum = v_sum >> 1;
          v_e   = v_e + 1;
        end
      end else begin
        v_sum = v_big - v_sml;
        for (int i = 0; i < AW; i++) begin
          if (v_sum != '0 && !v_sum[AW-2]) begin
            v_sum = v_sum << 1;
            v_e   = v_e - 1;
          end
        end
      end
      if (v_sum == '0) begin
        sum = '0;
      end else if (v_e >= int'(EXP_MAX)) begin
        overflow = 1'b1;
        sum      = {v_bs, EXP_MAX, {MANT_WIDTH{1'b0}}};
      end else if (v_e <= 0) begin
        underflow = 1'b1;
        sum       = {v_bs, {(BIT_WIDTH-1){1'b0}}};
      end else begin
        sum = {v_bs, v_e[EXP_WIDTH-1:0], v_sum[AW-3 -: MANT_WIDTH]};
      end
    end
  end
endmodule

module mac_unit #(
  parameter int BIT_WIDTH               = 16,
  parameter int EXP_WIDTH               = 8,
  parameter int MANT_WIDTH              = 7,
  parameter int TRUNC_MANTISSA_MBM_BITS = 6
) (
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  input  logic [BIT_WIDTH-1:0] in_c,
  output logic [BIT_WIDTH-1:0] mac_out,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow
);
  logic [BIT_WIDTH-1:0] w_prod;
  logic w_m_exc, w_m_ovf, w_m_unf, w_a_exc, w_a_ovf, w_a_unf;

  mac_mult #(.BIT_WIDTH(BIT_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH),
             .TRUNC_MANTISSA_MBM_BITS(TRUNC_MANTISSA_MBM_BITS)) u_mult (
    .in_a(in_a), .in_b(in_b), .prod(w_prod),
    .exception(w_m_exc), .overflow(w_m_ovf), .underflow(w_m_unf));

  mac_add #(.BIT_WIDTH(BIT_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH)) u_add (
    .in_x(w_prod), .in_c(in_c), .sum(mac_out),
    .exception(w_a_exc), .overflow(w_a_ovf), .underflow(w_a_unf));

  assign exception = w_m_exc | w_a_exc;
  assign overflow  = w_m_ovf | w_a_ovf;
  assign underflow = w_m_unf | w_a_unf;
endmodule

module mac_dot_controller #(
  parameter int BIT_WIDTH               = 16,
  parameter int EXP_WIDTH               = 8,
  parameter int MANT_WIDTH              = 7,
  parameter int TRUNC_MANTISSA_MBM_BITS = 6,
  parameter int LEN_WIDTH               = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic [BIT_WIDTH-1:0] acc_init,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [BIT_WIDTH-1:0] in_a,
  input  logic [BIT_WIDTH-1:0] in_b,
  input  logic                 abort,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_exc, r_ovf, r_unf, r_op_ready, r_res_valid, r_busy;
  logic [BIT_WIDTH-1:0] w_mac_out;
  logic                 w_exc, w_ovf, w_unf;

  mac_unit #(.BIT_WIDTH(BIT_WIDTH), .EXP_WIDTH(EXP_WIDTH), .MANT_WIDTH(MANT_WIDTH),
             .TRUNC_MANTISSA_MBM_BITS(TRUNC_MANTISSA_MBM_BITS)) u_mac (
    .in_a(in_a), .in_b(in_b), .in_c(r_acc), .mac_out(w_mac_out),
    .exception(w_exc), .overflow(w_ovf), .underflow(w_unf));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_exc       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_acc  <= acc_init;
          r_cnt  <= vec_len;
          r_exc  <= 1'b0;
          r_ovf  <= 1'b0;
          r_unf  <= 1'b0;
          r_busy <= 1'b1;
          if (vec_len != '0) begin
            r_state    <= S_RUN;
            r_op_ready <= 1'b1;
          end else begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end
        end
        S_RUN: if (abort) begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_busy     <= 1'b0;
        end else if (op_valid) begin
          r_acc <= w_mac_out;
          r_cnt <= r_cnt - 1'b1;
          r_exc <= r_exc | w_exc;
          r_ovf <= r_ovf | w_ovf;
          r_unf <= r_unf | w_unf;
          if (r_cnt == LEN_WIDTH'(1)) begin
            r_state     <= S_DONE;
            r_op_ready  <= 1'b0;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: if (abort || res_ready) begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_op_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign result    = r_acc;
  assign exception = r_exc;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_mac_dot_controller.sv
// Directed bench for mac_dot_controller: handshake timing, flags, abort and reset.
module tb_mac_dot_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic [15:0] acc_init = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        abort = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        exception, overflow, underflow, busy;

  int total = 0;
  int bad   = 0;

  mac_dot_controller dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .acc_init(acc_init),
    .op_valid(op_valid), .op_ready(op_ready), .in_a(in_a), .in_b(in_b), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .exception(exception), .overflow(overflow), .underflow(underflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] n, input logic [15:0] init);
    start = 1'b1; vec_len = n; acc_init = init;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    $display("job drained: result=%h flags(e,o,u)=%b", result, {exception, overflow, underflow});
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, op_ready, res_valid, exception, overflow, underflow} !== 6'b0 || result !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: ctl=%b result=%h required ctl=000000 result=0000",
               {busy, op_ready, res_valid, exception, overflow, underflow}, result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic(input string tag);
    start_job(8'd2, 16'h0000);
    total++;
    if ({busy, op_ready, res_valid} !== 3'b110) begin
      bad++; $display("FAIL %s_run_entry: ctl=%b required 110", tag, {busy, op_ready, res_valid});
    end
    op_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
    tick();
    total++;
    if (result !== 16'h4000 || res_valid !== 1'b0) begin
      bad++; $display("FAIL %s_first_pair: result=%h rv=%b required 4000 rv=0", tag, result, res_valid);
    end
    in_a = 16'h4000; in_b = 16'h4040;
    tick();
    op_valid = 1'b0;
    total++;
    if (res_valid !== 1'b1 || result !== 16'h4100 || {exception, overflow, underflow} !== 3'b000 || op_ready !== 1'b0) begin
      bad++; $display("FAIL %s_done: rv=%b result=%h flags=%b rdy=%b required rv=1 4100 000 rdy=0",
                      tag, res_valid, result, {exception, overflow, underflow}, op_ready);
    end
    drain();
    total++;
    if ({busy, res_valid} !== 2'b00) begin
      bad++; $display("FAIL %s_idle: busy,rv=%b required 00", tag, {busy, res_valid});
    end
  endtask

  task automatic test_zero_len();
    start_job(8'd0, 16'h3F00);
    total++;
    if (res_valid !== 1'b1 || result !== 16'h3F00 || op_ready !== 1'b0) begin
      bad++; $display("FAIL zero_len_done: rv=%b result=%h rdy=%b required rv=1 3f00 rdy=0", res_valid, result, op_ready);
    end
    drain();
    total++;
    if ({busy, op_ready} !== 2'b00) begin
      bad++; $display("FAIL zero_len_idle: busy,rdy=%b required 00", {busy, op_ready});
    end
  endtask

  task automatic test_gaps();
    logic [15:0] exp_sum [3] = '{16'h3F80, 16'h4000, 16'h4040};
    start_job(8'd3, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      op_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h3F80;
      tick();
      op_valid = 1'b0; in_a = 16'h4000;
      total++;
      if (result !== exp_sum[k]) begin
        bad++; $display("FAIL gap_accept%0d: result=%h required %h", k, result, exp_sum[k]);
      end
      if (k < 2) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          total++;
          if (result !== exp_sum[k] || res_valid !== 1'b0 || op_ready !== 1'b1) begin
            bad++; $display("FAIL gap_stall%0d_%0d: result=%h rv=%b rdy=%b required %h rv=0 rdy=1",
                            k, g, result, res_valid, op_ready, exp_sum[k]);
          end
        end
      end
    end
    for (int h = 0; h < 4; h++) begin
      start = 1'b1; vec_len = 8'd5; acc_init = 16'h1234;
      total++;
      if (res_valid !== 1'b1 || result !== 16'h4040) begin
        bad++; $display("FAIL gap_hold%0d: rv=%b result=%h required rv=1 4040", h, res_valid, result);
      end
      tick();
    end
    start = 1'b0;
    drain();
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL gap_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_overflow();
    start_job(8'd2, 16'h0000);
    op_valid = 1'b1; in_a = 16'h7F00; in_b = 16'h7F00;
    tick();
    total++;
    if (overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_set: overflow=%b required 1", overflow);
    end
    in_a = 16'h3F80; in_b = 16'h3F80;
    tick();
    op_valid = 1'b0;
    for (int h = 0; h < 2; h++) begin
      total++;
      if (res_valid !== 1'b1 || overflow !== 1'b1 || result !== 16'h7F80) begin
        bad++; $display("FAIL ovf_done%0d: rv=%b ovf=%b result=%h required rv=1 ovf=1 7f80", h, res_valid, overflow, result);
      end
      tick();
    end
    drain();
    total++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ovf_idle_sticky: ovf=%b busy=%b required ovf=1 busy=0", overflow, busy);
    end
    start_job(8'd1, 16'h0000);
    total++;
    if ({exception, overflow, underflow} !== 3'b000) begin
      bad++; $display("FAIL ovf_cleared: flags=%b required 000", {exception, overflow, underflow});
    end
    op_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h3F80;
    tick();
    op_valid = 1'b0;
    total++;
    if (result !== 16'h3F80 || res_valid !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_next_job: result=%h rv=%b ovf=%b required 3f80 rv=1 ovf=0", result, res_valid, overflow);
    end
    drain();
  endtask

  task automatic test_underflow();
    start_job(8'd1, 16'h0000);
    op_valid = 1'b1; in_a = 16'h0080; in_b = 16'h0080;
    tick();
    op_valid = 1'b0;
    total++;
    if (underflow !== 1'b1 || overflow !== 1'b0 || result !== 16'h0000) begin
      bad++; $display("FAIL unf_done: unf=%b ovf=%b result=%h required unf=1 ovf=0 0000", underflow, overflow, result);
    end
    drain();
  endtask

  task automatic test_abort();
    start_job(8'd4, 16'h0000);
    op_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
    tick();
    op_valid = 1'b0;
    start = 1'b1; vec_len = 8'd1; acc_init = 16'h3F80;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || op_ready !== 1'b1 || result !== 16'h4000) begin
      bad++; $display("FAIL abort_start_ignored: busy=%b rdy=%b result=%h required 1 1 4000", busy, op_ready, result);
    end
    abort = 1'b1; op_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4000;
    tick();
    abort = 1'b0; op_valid = 1'b0;
    total++;
    if ({busy, op_ready, res_valid} !== 3'b000 || result !== 16'h4000) begin
      bad++; $display("FAIL abort_run: ctl=%b result=%h required 000 4000", {busy, op_ready, res_valid}, result);
    end
    tick();
    total++;
    if (res_valid !== 1'b0) begin
      bad++; $display("FAIL abort_no_result: rv=%b required 0", res_valid);
    end
    start_job(8'd0, 16'h3F00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, res_valid} !== 2'b00 || result !== 16'h3F00) begin
      bad++; $display("FAIL abort_done: busy,rv=%b result=%h required 00 3f00", {busy, res_valid}, result);
    end
    $display("job aborted: result=%h", result);
  endtask

  task automatic test_max_len();
    start_job(8'd255, 16'h3F80);
    op_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000;
    repeat (254) tick();
    total++;
    if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      bad++; $display("FAIL max_len_254: rv=%b rdy=%b required rv=0 rdy=1", res_valid, op_ready);
    end
    tick();
    op_valid = 1'b0;
    total++;
    if (res_valid !== 1'b1 || result !== 16'h3F80) begin
      bad++; $display("FAIL max_len_255: rv=%b result=%h required rv=1 3f80", res_valid, result);
    end
    drain();
  endtask

  task automatic test_async_reset();
    start_job(8'd2, 16'h0000);
    op_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000;
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, op_ready, res_valid, exception, overflow, underflow} !== 6'b0 || result !== 16'h0) begin
      bad++; $display("FAIL async_reset: ctl=%b result=%h required 000000 0000",
                      {busy, op_ready, res_valid, exception, overflow, underflow}, result);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({busy, op_ready} !== 2'b00 || result !== 16'h0000) begin
      bad++; $display("FAIL post_reset_no_accept: busy,rdy=%b result=%h required 00 0000", {busy, op_ready}, result);
    end
    op_valid = 1'b0;
    test_basic("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_zero_len();
    test_gaps();
    test_overflow();
    test_underflow();
    test_abort();
    test_max_len();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
